soft_latch_bank: RTL and testbench

- Multi-channel successor to the single soft latch: CHANNELS independent zero-latency data-hold channels, each WIDTH bits wide.
- Each channel passes `in` straight through combinationally while its latch strobe is high, then holds the captured value.
- A held value can be released by an explicit clear, or released automatically after a programmable hold timeout.
- Sits between bursty producers (register strobes, decoded command fields) and consumers that sample later; exposes per-channel valid and expiry status.

---
 rtl/soft_latch_pkg.sv | 22 ++
 rtl/soft_latch_channel.sv | 110 +++++++++++
 rtl/soft_latch_bank.sv | 38 +++
 tb/tb_soft_latch_bank.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/soft_latch_pkg.sv
// Shared types and helpers for the soft latch bank.
// Channel FSM state encoding, overwrite counter width and timeout counter sizing.
package soft_latch_pkg;

    typedef enum logic {
        SL_EMPTY = 1'b0,
        SL_HELD  = 1'b1
    } sl_state_t;

    localparam int OVR_CNT_W = 8;

    // Width able to hold 0..timeout, never narrower than one bit.
    function automatic int sl_cnt_w(input int timeout);
        int w;
        w = 1;
        while ((1 << w) < (timeout + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/soft_latch_channel.sv
// One zero-latency hold channel: pass-through on latch, hold, clear and optional timeout.
// Optional overwrite counter enabled by SOFT_LATCH_BANK_OVERWRITE_CNT_EN.
module soft_latch_channel
    import soft_latch_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 0
) (
    input  logic                 clk,
    input  logic                 anrst,
    input  logic                 latch,
    input  logic                 clr,
    input  logic [WIDTH-1:0]     in,
    output logic [WIDTH-1:0]     out,
    output logic                 valid,
    output logic                 expired,
    output logic [OVR_CNT_W-1:0] ovr_cnt
);

    localparam int TW              = sl_cnt_w(TIMEOUT);
    localparam int LAST            = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TW-1:0] CNT_LAST = TW'(LAST);

    sl_state_t        state;
    sl_state_t        state_nxt;
    logic [WIDTH-1:0] hold_buf;
    logic [WIDTH-1:0] buf_nxt;
    logic [TW-1:0]    cnt;
    logic [TW-1:0]    cnt_nxt;
    logic             expired_q;
    logic             expired_nxt;

    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            state     <= SL_EMPTY;
            hold_buf  <= '0;
            cnt       <= '0;
            expired_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_buf  <= buf_nxt;
            cnt       <= cnt_nxt;
            expired_q <= expired_nxt;
        end
    end

    // Latch beats clear, clear beats the timeout; cnt never moves when TIMEOUT is 0.
    always_comb begin
        state_nxt   = state;
        buf_nxt     = hold_buf;
        cnt_nxt     = cnt;
        expired_nxt = 1'b0;
        if (latch) begin
            state_nxt = SL_HELD;
            buf_nxt   = in;
            cnt_nxt   = '0;
        end else if (clr) begin
            state_nxt = SL_EMPTY;
            buf_nxt   = '0;
            cnt_nxt   = '0;
        end else if ((state == SL_HELD) && (TIMEOUT > 0)) begin
            if (cnt == CNT_LAST) begin
                state_nxt   = SL_EMPTY;
                buf_nxt     = '0;
                cnt_nxt     = '0;
                expired_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    always_comb begin
        out = '0;
        if (!anrst) begin
            out = '0;
        end else if (latch) begin
            out = in;
        end else if (clr) begin
            out = '0;
        end else if (state == SL_HELD) begin
            out = hold_buf;
        end
    end

    assign valid   = anrst & (latch | ((state == SL_HELD) & ~clr));
    assign expired = anrst & expired_q;

`ifdef SOFT_LATCH_BANK_OVERWRITE_CNT_EN
    logic [OVR_CNT_W-1:0] ovr_q;

    // Counts captures that replace data still being held; saturates instead of wrapping.
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            ovr_q <= '0;
        end else if (latch) begin
            if ((state == SL_HELD) && (ovr_q != {OVR_CNT_W{1'b1}})) begin
                ovr_q <= ovr_q + 1'b1;
            end
        end else if (clr) begin
            ovr_q <= '0;
        end
    end

    assign ovr_cnt = ovr_q;
`else
    assign ovr_cnt = '0;
`endif

endmodule

// File: rtl/soft_latch_bank.sv
// Bank of independent soft latch channels; this level only slices the packed busses.
// Optional overwrite counters enabled by SOFT_LATCH_BANK_OVERWRITE_CNT_EN.
module soft_latch_bank
    import soft_latch_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int TIMEOUT  = 0
) (
    input  logic                          clk,
    input  logic                          anrst,
    input  logic [CHANNELS-1:0]           latch,
    input  logic [CHANNELS-1:0]           clr,
    input  logic [CHANNELS*WIDTH-1:0]     in,
    output logic [CHANNELS*WIDTH-1:0]     out,
    output logic [CHANNELS-1:0]           valid,
    output logic [CHANNELS-1:0]           expired,
    output logic [CHANNELS*OVR_CNT_W-1:0] ovr_cnt
);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        soft_latch_channel #(
            .WIDTH   (WIDTH),
            .TIMEOUT (TIMEOUT)
        ) u_ch (
            .clk     (clk),
            .anrst   (anrst),
            .latch   (latch[k]),
            .clr     (clr[k]),
            .in      (in[k*WIDTH +: WIDTH]),
            .out     (out[k*WIDTH +: WIDTH]),
            .valid   (valid[k]),
            .expired (expired[k]),
            .ovr_cnt (ovr_cnt[k*OVR_CNT_W +: OVR_CNT_W])
        );
    end

endmodule

// File: tb/tb_soft_latch_bank.sv
// Bench for soft_latch_bank: a TIMEOUT=0 and a TIMEOUT=4 bank share one stimulus stream.
// A timestamp-based model is compared every cycle, plus hand-computed literal checks.
module tb_soft_latch_bank;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int T1 = 4;

`ifdef SOFT_LATCH_BANK_OVERWRITE_CNT_EN
    localparam logic [7:0] OVR_SAT = 8'd255;
`else
    localparam logic [7:0] OVR_SAT = 8'd0;
`endif

    logic              clk;
    logic              anrst;
    logic [CH-1:0]     latch;
    logic [CH-1:0]     clr;
    logic [CH*W-1:0]   in;

    logic [1:0][CH*W-1:0] out_b;
    logic [1:0][CH-1:0]   valid_b;
    logic [1:0][CH-1:0]   expired_b;
    logic [1:0][CH*8-1:0] ovr_b;

    int checks;
    int errors;

    soft_latch_bank #(.WIDTH(W), .CHANNELS(CH), .TIMEOUT(0)) dut0 (
        .clk(clk), .anrst(anrst), .latch(latch), .clr(clr), .in(in),
        .out(out_b[0]), .valid(valid_b[0]), .expired(expired_b[0]), .ovr_cnt(ovr_b[0])
    );

    soft_latch_bank #(.WIDTH(W), .CHANNELS(CH), .TIMEOUT(T1)) dut4 (
        .clk(clk), .anrst(anrst), .latch(latch), .clr(clr), .in(in),
        .out(out_b[1]), .valid(valid_b[1]), .expired(expired_b[1]), .ovr_cnt(ovr_b[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each channel remembers what it captured and the cycle it did so.
    bit         m_cap     [2][CH];
    logic [7:0] m_val     [2][CH];
    int         m_cap_cyc [2][CH];
    int         m_ovr     [2][CH];
    int         cyc;

    initial begin
        cyc = 0;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < CH; k++) begin
                m_cap[d][k]     = 1'b0;
                m_val[d][k]     = '0;
                m_cap_cyc[d][k] = 0;
                m_ovr[d][k]     = 0;
            end
        end
    end

    function automatic int tmo(input int d);
        return (d == 0) ? 0 : T1;
    endfunction

    function automatic bit m_held(input int d, input int k);
        return m_cap[d][k] && ((tmo(d) == 0) || ((cyc - m_cap_cyc[d][k]) <= tmo(d)));
    endfunction

    function automatic bit m_expired(input int d, input int k);
        return m_cap[d][k] && (tmo(d) > 0) && ((cyc - m_cap_cyc[d][k]) == tmo(d) + 1);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < CH; k++) begin
                if (!anrst) begin
                    m_cap[d][k] = 1'b0;
                    m_ovr[d][k] = 0;
                end else if (latch[k]) begin
                    if (m_held(d, k) && m_ovr[d][k] < 255) m_ovr[d][k]++;
                    m_cap[d][k]     = 1'b1;
                    m_val[d][k]     = in[k*W +: W];
                    m_cap_cyc[d][k] = cyc;
                end else if (clr[k]) begin
                    m_cap[d][k] = 1'b0;
                    m_ovr[d][k] = 0;
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        logic [31:0] eo;
        logic [3:0]  ev;
        logic [3:0]  ee;
        logic [31:0] eovr;
        for (int d = 0; d < 2; d++) begin
            eo   = '0;
            ev   = '0;
            ee   = '0;
            eovr = '0;
            for (int k = 0; k < CH; k++) begin
                if (anrst) begin
                    if (latch[k]) eo[k*W +: W] = in[k*W +: W];
                    else if (!clr[k] && m_held(d, k)) eo[k*W +: W] = m_val[d][k];
                    ev[k] = latch[k] | (m_held(d, k) & ~clr[k]);
                    ee[k] = m_expired(d, k);
`ifdef SOFT_LATCH_BANK_OVERWRITE_CNT_EN
                    eovr[k*8 +: 8] = 8'(m_ovr[d][k]);
`endif
                end
            end
            check_output($sformatf("model out dut%0d cyc%0d", d, cyc), out_b[d], eo);
            check_output($sformatf("model valid dut%0d cyc%0d", d, cyc), 32'(valid_b[d]), 32'(ev));
            check_output($sformatf("model expired dut%0d cyc%0d", d, cyc), 32'(expired_b[d]), 32'(ee));
            check_output($sformatf("model ovr dut%0d cyc%0d", d, cyc), ovr_b[d], eovr);
        end
    end

    task automatic apply_stimulus(input logic [3:0] l, input logic [3:0] c, input logic [31:0] d);
        @(posedge clk);
        #2;
        latch = l;
        clr   = c;
        in    = d;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        anrst  = 1'b0;
        latch  = '0;
        clr    = '0;
        in     = '0;
        repeat (3) @(posedge clk);
        #2 anrst = 1'b1;
        #1;
        check_output("reset out", out_b[0], 32'h0);
        check_output("reset valid", 32'(valid_b[0]), 32'h0);
        check_output("reset expired", 32'(expired_b[1]), 32'h0);

        apply_stimulus(4'b0001, 4'b0000, 32'h000000A5);
        #1;
        check_output("ch0 passthrough", 32'(out_b[0][7:0]), 32'hA5);
        check_output("ch0 valid same cycle", 32'(valid_b[0]), 32'h1);
        for (int i = 0; i < 100; i++) apply_stimulus(4'b0000, 4'b0000, 32'(i * 32'h01010101));
        #1;
        check_output("ch0 held 100 cycles", out_b[0], 32'h000000A5);
        check_output("only ch0 valid", 32'(valid_b[0]), 32'h1);

        apply_stimulus(4'b0010, 4'b0000, 32'h00003C00);
        repeat (5) apply_stimulus(4'b0000, 4'b0000, 32'h0);
        #1;
        check_output("ch1 held", 32'(out_b[0][15:8]), 32'h3C);
        apply_stimulus(4'b0000, 4'b0010, 32'h0);
        #1;
        check_output("ch1 clr out", 32'(out_b[0][15:8]), 32'h0);
        check_output("ch1 clr valid", 32'(valid_b[0][1]), 32'h0);
        apply_stimulus(4'b0000, 4'b0000, 32'h0);
        #1;
        check_output("ch1 after clr", 32'(out_b[0][15:8]), 32'h0);

        apply_stimulus(4'b0100, 4'b0100, 32'h00770000);
        #1;
        check_output("ch2 latch+clr out", 32'(out_b[0][23:16]), 32'h77);
        check_output("ch2 latch+clr valid", 32'(valid_b[0][2]), 32'h1);
        apply_stimulus(4'b0000, 4'b0000, 32'h0);
        #1;
        check_output("ch2 held", 32'(out_b[0][23:16]), 32'h77);

        apply_stimulus(4'b0001, 4'b0000, 32'h00000011);
        for (int i = 1; i <= 4; i++) begin
            apply_stimulus(4'b0000, 4'b0000, 32'h0);
            #1;
            check_output($sformatf("t4 held c%0d", i), 32'(out_b[1][7:0]), 32'h11);
        end
        apply_stimulus(4'b0000, 4'b0000, 32'h0);
        #1;
        check_output("t4 expire pulse", 32'(expired_b[1][0]), 32'h1);
        check_output("t4 expire out", 32'(out_b[1][7:0]), 32'h0);
        check_output("t4 expire valid", 32'(valid_b[1][0]), 32'h0);
        apply_stimulus(4'b0000, 4'b0000, 32'h0);
        #1;
        check_output("t4 pulse one cycle", 32'(expired_b[1][0]), 32'h0);

        apply_stimulus(4'b0001, 4'b0000, 32'h00000011);
        repeat (3) apply_stimulus(4'b0000, 4'b0000, 32'h0);
        apply_stimulus(4'b0001, 4'b0000, 32'h00000022);
        for (int i = 5; i <= 8; i++) begin
            apply_stimulus(4'b0000, 4'b0000, 32'h0);
            #1;
            check_output($sformatf("t4 relatch c%0d out", i), 32'(out_b[1][7:0]), 32'h22);
            check_output($sformatf("t4 relatch c%0d expired", i), 32'(expired_b[1][0]), 32'h0);
        end
        apply_stimulus(4'b0000, 4'b0000, 32'h0);
        #1;
        check_output("t4 relatch expire", 32'(expired_b[1][0]), 32'h1);

        apply_stimulus(4'b1111, 4'b0000, 32'h44332211);
        apply_stimulus(4'b0000, 4'b0000, 32'h0);
        #1 anrst = 1'b0;
        #1;
        check_output("async reset out", out_b[0], 32'h0);
        check_output("async reset valid", 32'(valid_b[0]), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2 anrst = 1'b1;
        repeat (3) apply_stimulus(4'b0000, 4'b0000, 32'h0);
        #1;
        check_output("post reset empty dut0", 32'(valid_b[0]), 32'h0);
        check_output("post reset empty dut4", 32'(valid_b[1]), 32'h0);

        for (int i = 0; i < 300; i++) apply_stimulus(4'b1000, 4'b0000, {8'(i), 24'h0});
        apply_stimulus(4'b0000, 4'b0000, 32'h0);
        #1;
        check_output("ovr saturated", 32'(ovr_b[0][31:24]), 32'(OVR_SAT));
        apply_stimulus(4'b0000, 4'b1000, 32'h0);
        apply_stimulus(4'b0000, 4'b0000, 32'h0);
        #1;
        check_output("ovr cleared", 32'(ovr_b[0][31:24]), 32'h0);

        repeat (2) apply_stimulus(4'b0000, 4'b0000, 32'h0);
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
